// File: rtl/tx_eq_coeff_ctrl.sv
// TX FIR coefficient controller: validates pre/post-cursor requests against FS/LF and applies them on symbol boundaries.
// Define TX_EQ_PRESET_EN to add the preset_valid/preset_idx request path.
module tx_eq_coeff_ctrl #(
    parameter int         SYM_LEN       = 10,
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [5:0] RST_C0        = 6'd63
) (
    input  logic       bit_clk,
    input  logic       reset,
    input  logic [5:0] FS,
    input  logic [5:0] LF,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [5:0] req_pre,
    input  logic [5:0] req_post,
`ifdef TX_EQ_PRESET_EN
    input  logic       preset_valid,
    input  logic [3:0] preset_idx,
`endif
    output logic       rsp_valid,
    output logic       rsp_accept,
    output logic       busy,
    output logic       sym_boundary,
    output logic [5:0] C0,
    output logic [5:0] C1_plus,
    output logic [5:0] C1_minus
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CHECK,
        S_WAIT_BND,
        S_SETTLE,
        S_RESP
    } state_t;

    state_t     state_reg;
    logic [7:0] sym_cnt_reg;
    logic [7:0] settle_cnt_reg;
    logic [5:0] pre_h_reg;
    logic [5:0] post_h_reg;
    logic [5:0] fs_h_reg;
    logic [5:0] lf_h_reg;
    logic       bad_idx_reg;

    logic       cap_take;
    logic [5:0] cap_pre;
    logic [5:0] cap_post;
    logic       cap_bad;
    logic [7:0] sum;
    logic [8:0] need;
    logic       reject;

    always_ff @(posedge bit_clk or negedge reset) begin
        if (!reset) begin
            sym_cnt_reg <= 8'd0;
        end else if (sym_cnt_reg == 8'(SYM_LEN - 1)) begin
            sym_cnt_reg <= 8'd0;
        end else begin
            sym_cnt_reg <= sym_cnt_reg + 8'd1;
        end
    end

    assign sym_boundary = (sym_cnt_reg == 8'(SYM_LEN - 1));

`ifdef TX_EQ_PRESET_EN
    logic [5:0] preset_pre;
    logic [5:0] preset_post;

    always_comb begin
        preset_pre  = 6'd0;
        preset_post = 6'd0;
        case (preset_idx)
            4'd0: preset_post = 6'd6;
            4'd1: preset_post = 6'd4;
            4'd2: preset_post = 6'd5;
            4'd3: preset_post = 6'd3;
            4'd5: preset_pre  = 6'd2;
            4'd6: preset_pre  = 6'd3;
            4'd7: begin preset_pre = 6'd2; preset_post = 6'd5; end
            4'd8: begin preset_pre = 6'd3; preset_post = 6'd4; end
            4'd9: preset_pre  = 6'd4;
            default: ;
        endcase
    end

    // Presets win over explicit requests when both arrive together.
    always_comb begin
        cap_take = preset_valid || req_valid;
        cap_pre  = preset_valid ? preset_pre  : req_pre;
        cap_post = preset_valid ? preset_post : req_post;
        cap_bad  = preset_valid && (preset_idx > 4'd9);
    end
`else
    always_comb begin
        cap_take = req_valid;
        cap_pre  = req_pre;
        cap_post = req_post;
        cap_bad  = 1'b0;
    end
`endif

    // Margin rule evaluated as FS < 2*S + LF in 9 bits so a large S cannot wrap into a pass.
    always_comb begin
        sum    = {2'b00, pre_h_reg} + {2'b00, post_h_reg};
        need   = {sum, 1'b0} + {3'b000, lf_h_reg};
        reject = bad_idx_reg
              || (fs_h_reg < 6'd24)
              || (pre_h_reg > (fs_h_reg >> 2))
              || (sum > {2'b00, fs_h_reg})
              || ({3'b000, fs_h_reg} < need);
    end

    always_ff @(posedge bit_clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_INIT;
            req_ready      <= 1'b0;
            busy           <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_accept     <= 1'b0;
            C0             <= RST_C0;
            C1_plus        <= 6'd0;
            C1_minus       <= 6'd0;
            settle_cnt_reg <= 8'd0;
            pre_h_reg      <= 6'd0;
            post_h_reg     <= 6'd0;
            fs_h_reg       <= 6'd0;
            lf_h_reg       <= 6'd0;
            bad_idx_reg    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_reg)
                S_INIT: begin
                    if (sym_boundary) begin
                        C0        <= FS;
                        C1_plus   <= 6'd0;
                        C1_minus  <= 6'd0;
                        state_reg <= S_IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (cap_take) begin
                        pre_h_reg   <= cap_pre;
                        post_h_reg  <= cap_post;
                        bad_idx_reg <= cap_bad;
                        fs_h_reg    <= FS;
                        lf_h_reg    <= LF;
                        state_reg   <= S_CHECK;
                        req_ready   <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                S_CHECK: begin
                    if (reject) begin
                        state_reg  <= S_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_accept <= 1'b0;
                    end else begin
                        state_reg <= S_WAIT_BND;
                    end
                end
                S_WAIT_BND: begin
                    if (sym_boundary) begin
                        C0             <= fs_h_reg - sum[5:0];
                        C1_minus       <= pre_h_reg;
                        C1_plus        <= post_h_reg;
                        settle_cnt_reg <= 8'd0;
                        state_reg      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_reg == 8'(SETTLE_CYCLES - 1)) begin
                        state_reg  <= S_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_accept <= 1'b1;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + 8'd1;
                    end
                end
                S_RESP: begin
                    state_reg <= S_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state_reg <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_eq_coeff_ctrl.sv
// Scoreboard bench for tx_eq_coeff_ctrl: requests push expected responses, a monitor pops them on rsp_valid.
module tb_tx_eq_coeff_ctrl;
    localparam int SYM_LEN = 10;
    localparam int SETTLE  = 4;
    localparam int TO      = 300;

    logic       bit_clk = 1'b0;
    logic       reset   = 1'b0;
    logic [5:0] FS = 6'd63, LF = 6'd0, req_pre = 6'd0, req_post = 6'd0;
    logic       req_valid = 1'b0;
    logic       req_ready, rsp_valid, rsp_accept, busy, sym_boundary;
    logic [5:0] C0, C1_plus, C1_minus;
`ifdef TX_EQ_PRESET_EN
    logic       preset_valid = 1'b0;
    logic [3:0] preset_idx   = 4'd0;
`endif

    tx_eq_coeff_ctrl #(.SYM_LEN(SYM_LEN), .SETTLE_CYCLES(SETTLE), .RST_C0(6'd63)) dut (
        .bit_clk(bit_clk), .reset(reset), .FS(FS), .LF(LF),
        .req_valid(req_valid), .req_ready(req_ready), .req_pre(req_pre), .req_post(req_post),
`ifdef TX_EQ_PRESET_EN
        .preset_valid(preset_valid), .preset_idx(preset_idx),
`endif
        .rsp_valid(rsp_valid), .rsp_accept(rsp_accept), .busy(busy), .sym_boundary(sym_boundary),
        .C0(C0), .C1_plus(C1_plus), .C1_minus(C1_minus)
    );

    typedef struct {
        int         cyc;
        bit         acc;
        logic [5:0] c0, cp, cm;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc;
    int         last_rsp;
    logic [5:0] m_c0 = 6'd63, m_cp = 6'd0, m_cm = 6'd0;
    logic [17:0] prev_coef;

    always #5 bit_clk = ~bit_clk;

    // Period index since reset release; the symbol counter equals cyc % SYM_LEN in that period.
    always @(posedge bit_clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, act, req);
        end
    endtask

    function automatic bit model_ok(int fs, int lf, int pre, int post);
        int s = pre + post;
        return !(fs < 24 || pre > fs / 4 || s > fs || fs - 2 * s < lf);
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge bit_clk);
            if (reset && rsp_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp at cycle %0d: got rsp_valid=1 want none", cyc);
                end else begin
                    e = q.pop_front();
                    $display("rsp cycle %0d accept %0d C0 %0d C1_minus %0d C1_plus %0d",
                             cyc, rsp_accept, C0, C1_minus, C1_plus);
                    chk("rsp_cycle", cyc, e.cyc);
                    chk("rsp_accept", int'(rsp_accept), int'(e.acc));
                    chk("rsp_C0", int'(C0), int'(e.c0));
                    chk("rsp_C1_minus", int'(C1_minus), int'(e.cm));
                    chk("rsp_C1_plus", int'(C1_plus), int'(e.cp));
                end
            end
        end
    end

    // Any coefficient change outside reset must land in the period right after a boundary edge.
    always @(negedge bit_clk) begin
        if (!reset) begin
            prev_coef = {C0, C1_plus, C1_minus};
        end else if ({C0, C1_plus, C1_minus} != prev_coef) begin
            chk("coef_change_on_boundary", cyc % SYM_LEN, 0);
            prev_coef = {C0, C1_plus, C1_minus};
        end
    end

    task automatic wait_cyc(int n);
        while (cyc < n) @(negedge bit_clk);
    endtask

    task automatic check_reset(string tag);
        $display("reset check %s", tag);
        chk({tag, "_C0"}, int'(C0), 63);
        chk({tag, "_C1_plus"}, int'(C1_plus), 0);
        chk({tag, "_C1_minus"}, int'(C1_minus), 0);
        chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        chk({tag, "_rsp_accept"}, int'(rsp_accept), 0);
        chk({tag, "_busy"}, int'(busy), 1);
        chk({tag, "_req_ready"}, int'(req_ready), 0);
        chk({tag, "_sym_boundary"}, int'(sym_boundary), 0);
    endtask

    // Called at a falling edge; k is the rising edge on which the handshake lands.
    task automatic issue(int fs, int lf, int pre, int post, bit keep, output int k);
        int   n = 0;
        bit   ok;
        exp_t e;
        FS = 6'(fs); LF = 6'(lf); req_pre = 6'(pre); req_post = 6'(post);
        req_valid = 1'b1;
        while (!req_ready && n < TO) begin
            @(negedge bit_clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout at cycle %0d: got req_ready=0 want 1", cyc);
            req_valid = 1'b0;
            k = -1;
            return;
        end
        k  = cyc + 1;
        ok = model_ok(fs, lf, pre, post);
        if (ok) begin
            e.cyc = ((k + 2 + SYM_LEN - 1) / SYM_LEN) * SYM_LEN + SETTLE;
            m_c0  = 6'(fs - pre - post);
            m_cm  = 6'(pre);
            m_cp  = 6'(post);
        end else begin
            e.cyc = k + 1;
        end
        e.acc = ok; e.c0 = m_c0; e.cp = m_cp; e.cm = m_cm;
        q.push_back(e);
        last_rsp = e.cyc;
        $display("req edge %0d FS %0d LF %0d pre %0d post %0d expect accept %0d at cycle %0d",
                 k, fs, lf, pre, post, ok, e.cyc);
        @(negedge bit_clk);
        if (keep) begin
            req_pre  = 6'(pre + 1);
            req_post = 6'(post + 3);
        end else begin
            req_valid = 1'b0;
        end
        // Pin changes after capture must not affect the pending request.
        FS = 6'($urandom_range(0, 63));
        LF = 6'($urandom_range(0, 63));
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < TO) begin
            @(negedge bit_clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout at cycle %0d: got %0d pending want 0", cyc, q.size());
            q.delete();
        end
        @(negedge bit_clk);
    endtask

    initial begin : stim
        int k, k2, r1;
        repeat (3) @(negedge bit_clk);
        check_reset("por");
        #1 reset = 1'b1;

        // Bring-up: INIT loads C0=FS at the first boundary.
        wait_cyc(SYM_LEN - 1);
        chk("init_sym_boundary", int'(sym_boundary), 1);
        chk("init_req_ready_pre", int'(req_ready), 0);
        chk("init_busy_pre", int'(busy), 1);
        wait_cyc(SYM_LEN);
        chk("init_C0", int'(C0), 63);
        chk("init_C1_plus", int'(C1_plus), 0);
        chk("init_C1_minus", int'(C1_minus), 0);
        chk("init_req_ready", int'(req_ready), 1);
        chk("init_busy", int'(busy), 0);
        chk("init_sym_boundary_low", int'(sym_boundary), 0);

        issue(63, 0, 10, 10, 1'b0, k); drain();
        issue(63, 0, 16, 0, 1'b0, k);  drain();
        issue(24, 8, 4, 4, 1'b0, k);   drain();
        issue(24, 8, 5, 4, 1'b0, k);   drain();

        // Requester holds req_valid through SETTLE; the second one is taken only back in IDLE.
        issue(63, 0, 8, 8, 1'b1, k);
        r1 = last_rsp;
        issue(63, 0, 3, 2, 1'b0, k2);
        chk("second_req_edge", k2, r1 + 2);
        drain();

        // Reset while waiting for the boundary: pending request dropped, no response.
        issue(63, 0, 5, 5, 1'b0, k);
        @(negedge bit_clk);
        #1 reset = 1'b0;
        #1 check_reset("mid_op");
        q.delete();
        FS = 6'd40; LF = 6'd0;
        @(negedge bit_clk);
        #1 reset = 1'b1;
        m_c0 = 6'd40; m_cp = 6'd0; m_cm = 6'd0;
        wait_cyc(SYM_LEN - 1);
        chk("reinit_C0_pre", int'(C0), 63);
        chk("reinit_req_ready_pre", int'(req_ready), 0);
        wait_cyc(SYM_LEN);
        chk("reinit_C0", int'(C0), 40);
        chk("reinit_req_ready", int'(req_ready), 1);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge bit_clk);
            issue($urandom_range(16, 63), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 15),
                  $urandom_range(0, 17), $urandom_range(0, 30), 1'b0, k);
            drain();
        end

        repeat (5) @(negedge bit_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_eq_coeff_ctrl.md
Name: tx_eq_coeff_ctrl

Overview:
- Controller that owns the C0/C1_plus/C1_minus coefficient inputs of the TX FIR driver.
- Accepts coefficient-change requests (pre-cursor/post-cursor) from link-training logic and validates them against FS/LF rules.
- Derives C0 = FS - pre - post, and applies the new set only on a symbol boundary so the driver never changes taps mid-symbol.
- Returns an accept/reject response after a settle interval.

Parameters:
SYM_LEN, 10, bit_clk cycles per symbol; coefficients change only when the symbol counter wraps (2..255).
SETTLE_CYCLES, 4, bit_clk cycles held after apply before the response (1..255).
RST_C0, 63, C0 value driven during reset.

Ports:
bit_clk  input  1  bit clock, all state on rising edge.
reset  input  1  asynchronous, active-low reset.
FS  input  6  full-swing value from PHY config; valid range 24..63.
LF  input  6  low-frequency limit from PHY config.
req_valid  input  1  coefficient request valid.
req_ready  output  1  high only in IDLE.
req_pre  input  6  requested C1_minus magnitude.
req_post  input  6  requested C1_plus magnitude.
rsp_valid  output  1  one-cycle response strobe.
rsp_accept  output  1  qualifies rsp_valid: 1=applied, 0=rejected.
busy  output  1  high in any state other than IDLE.
sym_boundary  output  1  high in the last bit_clk cycle of each symbol.
C0  output  6  main-cursor coefficient to the driver.
C1_plus  output  6  post-cursor coefficient to the driver.
C1_minus  output  6  pre-cursor coefficient to the driver.

Behaviour:
- Reset values (asynchronous, reset=0):
  - C0=RST_C0, C1_plus=0, C1_minus=0.
  - rsp_valid=0, rsp_accept=0, busy=1, req_ready=0, sym_boundary=0.
  - Symbol counter sym_cnt=0; state INIT.
- Symbol counter:
  - sym_cnt increments every cycle and wraps SYM_LEN-1 -> 0.
  - sym_boundary = (sym_cnt == SYM_LEN-1).
  - The counter runs in all states.
- FSM states:
  - INIT: at the first sym_boundary after reset release, load C0=FS, C1_plus=0, C1_minus=0; go to IDLE.
  - IDLE: req_ready=1. On the edge where req_valid && req_ready, capture req_pre, req_post, FS and LF into holding regs; go to CHECK. Later changes to FS/LF are ignored until the next request.
  - CHECK (1 cycle): compute in 8-bit unsigned, S = pre + post. Reject if any of:
    - FS < 24
    - pre > (FS >> 2)
    - S > FS
    - FS - 2*S < LF (i.e. C0 - pre - post < LF)
  - CHECK exits: on reject go to RESP with rsp_accept=0; otherwise go to WAIT_BND.
  - WAIT_BND: wait for sym_boundary. On that edge, C0 <= FS_h - S, C1_minus <= pre, C1_plus <= post, all three in the same edge. Go to SETTLE. If sym_boundary is already high on entry, apply on that same edge.
  - SETTLE: count SETTLE_CYCLES cycles, then go to RESP with rsp_accept=1.
  - RESP: rsp_valid=1 for exactly one cycle with rsp_accept valid; go to IDLE. rsp_accept holds its value until the next RESP.
- Latency, with request handshake on edge k:
  - Reject: rsp_valid high in cycle k+2.
  - Accept: coefficients change at the first sym_boundary edge >= k+2; rsp_valid is high SETTLE_CYCLES+1 cycles after that edge.
- req_valid outside IDLE is ignored; there is no queue. The requester must hold req_valid until req_ready.
- Coefficient outputs change only in INIT and WAIT_BND, and only on a sym_boundary edge.
- Reset mid-operation: every output returns to its reset value immediately; a pending request is dropped and no response is issued.

Optional Feature:
- Macro: TX_EQ_PRESET_EN.
- When defined:
  - Adds input preset_valid (1) and input preset_idx (4).
  - In IDLE, preset_valid has priority over req_valid.
  - The index maps via a constant table to (pre, post): P0 0/6, P1 0/4, P2 0/5, P3 0/3, P4 0/0, P5 2/0, P6 3/0, P7 2/5, P8 3/4, P9 4/0.
  - The mapped values then follow the same CHECK/WAIT_BND/SETTLE/RESP path.
  - preset_idx >= 10 is rejected in CHECK.
- When undefined: the ports are absent and behaviour is unchanged.

Test Plan:
1. FS=63, LF=0, release reset -> C0=63, C1_plus=0, C1_minus=0 after the first boundary; req_ready=1.
2. FS=63, LF=0, pre=10, post=10 -> accept. C0=43, C1_minus=10, C1_plus=10 change together on the sym_boundary edge; rsp_valid,rsp_accept=1 exactly 5 cycles later.
3. FS=63, pre=16, post=0 -> reject (16 > 15). rsp_valid at k+2 with rsp_accept=0; coefficients unchanged.
4. FS=24, LF=8, pre=4, post=4 -> accept with C0=16 (margin 8 == LF). Then pre=5, post=4 -> reject (6 < 8).
5. Request accepted, assert reset during WAIT_BND -> outputs immediately 63/0/0; rsp_valid never pulses; after release, INIT reloads C0=FS.
6. req_valid held high during SETTLE with different values -> ignored. Second request is taken only in IDLE; both responses appear, in order, each one cycle wide.
